// File: rtl/spi_byte_rx.sv
// SPI slave byte receiver (modes 0/3): synchronizes the pins to clk_in and assembles 8-bit bytes with their D/C flag.
// byte_rdy_out rises on the (SYNC_STAGES+2)th clk_in edge, counting the edge that first samples SCLK high for bit 8. There is no backpressure; each byte is a one-cycle strobe.
module spi_byte_rx #(
    parameter int SYNC_STAGES = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       spi_sclk_in,
    input  logic       spi_mosi_in,
    input  logic       spi_cs_n_in,
    input  logic       spi_dc_in,
    output logic       dc_out,
    output logic       byte_rdy_out,
    output logic [7:0] byte_data_out,
    output logic       abort_out
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sr, mosi_sr, cs_sr, dc_sr;
    logic                   sclk_sync, mosi_sync, cs_sync, dc_sync;
    logic                   sclk_d, sclk_rise;

    logic [2:0] bit_cnt;
    logic [7:0] shreg, shreg_next;
    logic       shift_en, abort_d;
    logic       done_q, dc_cap;

    // Chains reset to bus-idle levels so no false SCLK edge appears after reset
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sclk_sr <= '1;
            cs_sr   <= '1;
            mosi_sr <= '0;
            dc_sr   <= '0;
            sclk_d  <= 1'b1;
        end else begin
            sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], spi_sclk_in};
            cs_sr   <= {cs_sr[SYNC_STAGES-2:0], spi_cs_n_in};
            mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi_in};
            dc_sr   <= {dc_sr[SYNC_STAGES-2:0], spi_dc_in};
            sclk_d  <= sclk_sync;
        end
    end

    assign sclk_sync = sclk_sr[SYNC_STAGES-1];
    assign cs_sync   = cs_sr[SYNC_STAGES-1];
    assign mosi_sync = mosi_sr[SYNC_STAGES-1];
    assign dc_sync   = dc_sr[SYNC_STAGES-1];
    assign sclk_rise = sclk_sync & ~sclk_d;

    always_comb begin
        shreg_next = shreg;
        if (MSB_FIRST) begin
            shreg_next = {shreg[6:0], mosi_sync};
        end else begin
            shreg_next = {mosi_sync, shreg[7:1]};
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // CS deassertion takes priority over a coincident SCLK edge
    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        abort_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!cs_sync) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_sync) begin
                    state_d = IDLE;
                    abort_d = (bit_cnt != 3'd0);
                end else if (sclk_rise) begin
                    shift_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            done_q    <= 1'b0;
            dc_cap    <= 1'b0;
            abort_out <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            abort_out <= abort_d;
            if (state_q == IDLE || state_d == IDLE) begin
                bit_cnt <= '0;
                if (state_q == SHIFT) begin
                    shreg <= '0;
                end
            end else if (shift_en) begin
                shreg   <= shreg_next;
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    done_q <= 1'b1;
                    dc_cap <= dc_sync;
                end
            end
        end
    end

    // Output stage holds the last byte between strobes
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            byte_rdy_out  <= 1'b0;
            byte_data_out <= '0;
            dc_out        <= 1'b0;
        end else begin
            byte_rdy_out <= done_q;
            if (done_q) begin
                byte_data_out <= shreg;
                dc_out        <= dc_cap;
            end
        end
    end

endmodule

// File: tb/tb_spi_byte_rx.sv
// Directed bench for spi_byte_rx: an MSB-first and an LSB-first instance share the same SPI pins.
module tb_spi_byte_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk, mosi, cs_n, dc;
    logic       dc_o, rdy, abort;
    logic [7:0] data;
    logic       lsb_dc, lsb_rdy, lsb_abort;
    logic [7:0] lsb_data;

    int checks = 0;
    int passed = 0;
    int rdy_cnt = 0;
    int abort_cnt = 0;
    int lsb_rdy_cnt = 0;
    int lsb_abort_cnt = 0;
    int dbl = 0;
    logic rdy_prev = 1'b0;
    logic [8:0] rxq[$];
    int lat;
    int base_rdy, base_abort;

    always #5 clk = ~clk;

    spi_byte_rx #(.SYNC_STAGES(2), .MSB_FIRST(1'b1)) dut (
        .clk_in(clk), .rst_in(rst),
        .spi_sclk_in(sclk), .spi_mosi_in(mosi), .spi_cs_n_in(cs_n), .spi_dc_in(dc),
        .dc_out(dc_o), .byte_rdy_out(rdy), .byte_data_out(data), .abort_out(abort)
    );

    spi_byte_rx #(.SYNC_STAGES(2), .MSB_FIRST(1'b0)) dut_lsb (
        .clk_in(clk), .rst_in(rst),
        .spi_sclk_in(sclk), .spi_mosi_in(mosi), .spi_cs_n_in(cs_n), .spi_dc_in(dc),
        .dc_out(lsb_dc), .byte_rdy_out(lsb_rdy), .byte_data_out(lsb_data), .abort_out(lsb_abort)
    );

    always @(posedge clk) begin
        #1;
        if (rdy) begin
            rdy_cnt++;
            rxq.push_back({dc_o, data});
            if (rdy_prev) dbl++;
        end
        rdy_prev = rdy;
        if (abort) abort_cnt++;
        if (lsb_rdy) lsb_rdy_cnt++;
        if (lsb_abort) lsb_abort_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input logic d);
        mosi = b;
        dc   = d;
        sclk = 1'b0;
        tick(4);
        sclk = 1'b1;
        tick(4);
    endtask

    task automatic send_byte(input logic [7:0] v, input logic d);
        for (int i = 7; i >= 0; i--) send_bit(v[i], d);
    endtask

    initial begin
        rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; dc = 1'b0;
        tick(3);
        check("rst_rdy", rdy, 1'b0);
        check("rst_data", data, 8'h00);
        check("rst_dc", dc_o, 1'b0);
        check("rst_abort", abort, 1'b0);
        rst = 1'b0;
        tick(3);

        // Test 1: mode 0, 8'hCC, D/C = 0, latency measured on bit 8
        cs_n = 1'b0;
        tick(6);
        for (int i = 7; i >= 1; i--) send_bit(1'(8'hCC >> i), 1'b0);
        mosi = 1'b0;
        sclk = 1'b0;
        tick(4);
        sclk = 1'b1;
        lat = 11;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (rdy) begin
                lat = k;
                break;
            end
        end
        tick(2);
        check("t1_latency", lat, 4);
        check("t1_data", data, 8'hCC);
        check("t1_dc", dc_o, 1'b0);
        tick(6);
        check("t1_count", rdy_cnt, 1);

        // Test 2: back-to-back burst, mode 0 then mode 3
        rxq.delete();
        base_rdy = rdy_cnt;
        send_byte(8'hDA, 1'b0);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        tick(6);
        check("t2m0_count", rdy_cnt - base_rdy, 4);
        check("t2m0_b0", rxq[0], {1'b0, 8'hDA});
        check("t2m0_b1", rxq[1], {1'b1, 8'h11});
        check("t2m0_b2", rxq[2], {1'b1, 8'h22});
        check("t2m0_b3", rxq[3], {1'b1, 8'h33});
        cs_n = 1'b1;
        tick(8);
        check("t2_no_abort", abort_cnt, 0);
        cs_n = 1'b0;
        tick(6);
        rxq.delete();
        base_rdy = rdy_cnt;
        send_byte(8'hDA, 1'b0);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        tick(6);
        check("t2m3_count", rdy_cnt - base_rdy, 4);
        check("t2m3_b0", rxq[0], {1'b0, 8'hDA});
        check("t2m3_b1", rxq[1], {1'b1, 8'h11});
        check("t2m3_b3", rxq[3], {1'b1, 8'h33});

        // Test 3: partial byte aborted, then a full byte from counter 0
        base_rdy = rdy_cnt;
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        cs_n = 1'b1;
        tick(8);
        check("t3_abort", abort_cnt, 1);
        check("t3_no_rdy", rdy_cnt - base_rdy, 0);
        cs_n = 1'b0;
        tick(6);
        send_byte(8'hA5, 1'b1);
        tick(6);
        check("t3_count", rdy_cnt - base_rdy, 1);
        check("t3_data", data, 8'hA5);
        check("t3_dc", dc_o, 1'b1);

        // Test 4: wire pattern 1,0,0,0,0,0,0,0 on both bit orders
        send_byte(8'h80, 1'b0);
        tick(6);
        check("t4_msb", data, 8'h80);
        check("t4_lsb", lsb_data, 8'h01);
        check("t4_lsb_dc", lsb_dc, 1'b0);

        // Test 5: D/C sampled only at bit 8; SCLK activity with CS_N high
        for (int i = 7; i >= 0; i--) send_bit(1'(8'h5A >> i), (i == 0) ? 1'b1 : 1'(i % 2));
        tick(6);
        check("t5_dc1", dc_o, 1'b1);
        check("t5_data1", data, 8'h5A);
        for (int i = 7; i >= 0; i--) send_bit(1'(8'hC3 >> i), (i == 0) ? 1'b0 : 1'b1);
        tick(6);
        check("t5_dc0", dc_o, 1'b0);
        check("t5_data0", data, 8'hC3);
        cs_n = 1'b1;
        tick(8);
        base_rdy   = rdy_cnt;
        base_abort = abort_cnt;
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b1);
        tick(4);
        check("t5_idle_rdy", rdy_cnt - base_rdy, 0);
        check("t5_idle_abort", abort_cnt - base_abort, 0);
        cs_n = 1'b0;
        tick(6);
        send_byte(8'h96, 1'b1);
        tick(6);
        check("t5_after_count", rdy_cnt - base_rdy, 1);
        check("t5_after_data", data, 8'h96);

        // Test 6: reset mid-byte with CS_N held low and SCLK high
        base_abort = abort_cnt;
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
        rst = 1'b1;
        tick(3);
        check("t6_rst_data", data, 8'h00);
        check("t6_rst_dc", dc_o, 1'b0);
        check("t6_rst_rdy", rdy, 1'b0);
        check("t6_rst_abort", abort, 1'b0);
        rst = 1'b0;
        base_rdy = rdy_cnt;
        tick(8);
        check("t6_no_spurious", rdy_cnt - base_rdy, 0);
        send_byte(8'h3C, 1'b0);
        tick(6);
        check("t6_count", rdy_cnt - base_rdy, 1);
        check("t6_data", data, 8'h3C);
        check("t6_abort_total", abort_cnt - base_abort, 0);

        check("no_double_rdy", dbl, 0);
        check("lsb_rdy_total", lsb_rdy_cnt, rdy_cnt);
        check("lsb_abort_total", lsb_abort_cnt, abort_cnt);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
